// File: rtl/fp_pkg.sv
// Shared single-precision FPU definitions: rounding modes, fflags bit
// positions, canonical constants and the packed binary32 layout.
package fp_pkg;

    // RISC-V rounding modes after decode has resolved DYN and illegal codes.
    typedef enum logic [2:0] {
        RM_RNE = 3'b000,
        RM_RTZ = 3'b001,
        RM_RDN = 3'b010,
        RM_RUP = 3'b011,
        RM_RMM = 3'b100
    } rm_e;

    // Bit positions inside fflags = {NV, DZ, OF, UF, NX}.
    localparam int FLAG_NX = 0;
    localparam int FLAG_UF = 1;
    localparam int FLAG_OF = 2;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_NV = 4;

    localparam logic [31:0] CANON_NAN  = 32'h7FC0_0000;
    localparam logic [30:0] MAX_FINITE = 31'h7F7F_FFFF;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;

endpackage

// File: rtl/fp_round_decide.sv
// Rounding-increment decision shared by the add, multiply and convert
// datapaths. Purely combinational.
module fp_round_decide
    import fp_pkg::*;
(
    input  logic       sign,
    input  logic       lsb,
    input  logic [2:0] grs,
    input  logic [2:0] rm,
    output logic       inc,
    output logic       inexact
);

    // Select the increment for the active rounding mode; unused codes fall back to RNE.
    always_comb begin
        inexact = |grs;
        case (rm_e'(rm))
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = sign & inexact;
            RM_RUP:  inc = ~sign & inexact;
            RM_RMM:  inc = grs[2];
            default: inc = grs[2] & (grs[1] | grs[0] | lsb);
        endcase
    end

endmodule

// File: rtl/fadd_round_pack.sv
// Final add/sub stage: rounds the normalised value, handles carry-out and
// overflow, and packs the IEEE-754 result with fflags. Two-stage
// valid/ready pipeline that holds its output under back-pressure.
module fadd_round_pack
    import fp_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    valid_in,
    output logic                    ready_in,
    input  logic                    sign_in,
    input  logic [EXP_W-1:0]        exp_in,
    input  logic [FRAC_W-1:0]       frac_in,
    input  logic [2:0]              grs_in,
    input  logic [2:0]              rm_in,
    input  logic                    nan_in,
    input  logic                    inf_in,
    input  logic                    invalid_in,
    input  logic                    underflow_in,
    output logic                    valid_out,
    input  logic                    ready_out,
    output logic [EXP_W+FRAC_W:0]   result,
    output logic [4:0]              fflags
);

    localparam int EF_W = EXP_W + FRAC_W;
    localparam logic [EXP_W-1:0] EXP_ALL1 = '1;
    localparam logic [EXP_W-1:0] EXP_MAXF = EXP_ALL1 - 1'b1;

    // Handshake / stage occupancy
    logic s1_valid_q;
    logic s2_valid_q;
    logic s1_adv;
    logic s2_adv;

    // Stage 1 state
    logic              s1_sign_q;
    logic [EXP_W-1:0]  s1_exp_q;
    logic [FRAC_W-1:0] s1_frac_q;
    logic [2:0]        s1_rm_q;
    logic              s1_inc_q;
    logic              s1_nx_q;
    logic              s1_nan_q;
    logic              s1_inf_q;
    logic              s1_nv_q;
    logic              s1_tiny_q;
    logic              s1_expmax_q;

    // Stage 2 state
    logic [EF_W:0] result_q;
    logic [EF_W:0] result_d;
    logic [4:0]    fflags_q;
    logic [4:0]    fflags_d;

    logic          rd_inc;
    logic          rd_nx;
    logic [EF_W-1:0] rounded;
    logic          ovf;
    logic [EF_W:0] inf_val;
    logic [EF_W:0] maxf_val;

    // A stage moves forward when it is empty or its consumer takes data;
    // ready_in therefore depends only on ready_out and the stage valids.
    assign s2_adv   = ~s2_valid_q | ready_out;
    assign s1_adv   = ~s1_valid_q | s2_adv;
    assign ready_in = s1_adv;

    fp_round_decide u_round_decide (
        .sign    (sign_in),
        .lsb     (frac_in[0]),
        .grs     (grs_in),
        .rm      (rm_in),
        .inc     (rd_inc),
        .inexact (rd_nx)
    );

    // Stage 1 valid: refills whenever the stage is allowed to advance.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
        end else if (s1_adv) begin
            s1_valid_q <= valid_in;
        end
    end

    // Stage 1 payload: operand, rounding decision and special/overflow class.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_sign_q   <= 1'b0;
            s1_exp_q    <= '0;
            s1_frac_q   <= '0;
            s1_rm_q     <= '0;
            s1_inc_q    <= 1'b0;
            s1_nx_q     <= 1'b0;
            s1_nan_q    <= 1'b0;
            s1_inf_q    <= 1'b0;
            s1_nv_q     <= 1'b0;
            s1_tiny_q   <= 1'b0;
            s1_expmax_q <= 1'b0;
        end else if (valid_in && s1_adv) begin
            s1_sign_q   <= sign_in;
            s1_exp_q    <= exp_in;
            s1_frac_q   <= frac_in;
            s1_rm_q     <= rm_in;
            s1_inc_q    <= rd_inc;
            s1_nx_q     <= rd_nx;
            s1_nan_q    <= nan_in;
            s1_inf_q    <= inf_in;
            s1_nv_q     <= invalid_in;
            s1_tiny_q   <= (exp_in == '0) | underflow_in;
            s1_expmax_q <= (exp_in == EXP_ALL1) & ~nan_in & ~inf_in;
        end
    end

    // Exponent and fraction are added as one field so a mantissa carry
    // bumps the exponent (covers subnormal->normal and 1.111..->10.0).
    assign rounded  = {s1_exp_q, s1_frac_q} + EF_W'(s1_inc_q);
    assign ovf      = (rounded[EF_W-1:FRAC_W] == EXP_ALL1) | s1_expmax_q;
    assign inf_val  = {s1_sign_q, EXP_ALL1, {FRAC_W{1'b0}}};
    assign maxf_val = {s1_sign_q, EXP_MAXF, {FRAC_W{1'b1}}};

    // Pack the result: specials override overflow, which overrides the plain rounded value.
    always_comb begin
        result_d          = {s1_sign_q, rounded};
        fflags_d          = '0;
        fflags_d[FLAG_NX] = s1_nx_q;
        fflags_d[FLAG_UF] = s1_tiny_q & s1_nx_q;
        fflags_d[FLAG_NV] = s1_nv_q;
        if (ovf) begin
            fflags_d[FLAG_OF] = 1'b1;
            fflags_d[FLAG_NX] = 1'b1;
            case (rm_e'(s1_rm_q))
                RM_RTZ:  result_d = maxf_val;
                RM_RDN:  result_d = s1_sign_q ? inf_val : maxf_val;
                RM_RUP:  result_d = s1_sign_q ? maxf_val : inf_val;
                default: result_d = inf_val;
            endcase
        end
        if (s1_inf_q) begin
            result_d          = inf_val;
            fflags_d          = '0;
            fflags_d[FLAG_NV] = s1_nv_q;
        end
        if (s1_nan_q) begin
            result_d          = {1'b0, EXP_ALL1, 1'b1, {(FRAC_W-1){1'b0}}};
            fflags_d          = '0;
            fflags_d[FLAG_NV] = s1_nv_q;
        end
    end

    // Stage 2 valid: takes stage 1's valid whenever the output is free or drained.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid_q <= 1'b0;
        end else if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
        end
    end

    // Stage 2 payload: only loaded with real data so the outputs stay put while stalled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result_q <= '0;
            fflags_q <= '0;
        end else if (s1_valid_q && s2_adv) begin
            result_q <= result_d;
            fflags_q <= fflags_d;
        end
    end

    assign valid_out = s2_valid_q;
    assign result    = result_q;
    assign fflags    = fflags_q;

endmodule
